atm_account_server: RTL and testbench

- Bank-side responder for the ATM front-end controller. It accepts one transaction request at a time and returns one response.
- Holds a small register-based account table: account number, PIN, balance, failed-PIN counter, lock flag.
- Performs authentication, balance, withdraw, deposit and exit operations against a single open session.
- The ATM controller is the initiator; this block sits behind it on a valid/ready request/response link.

---
 rtl/atm_pkg.sv | 24 ++
 rtl/atm_account_table.sv | 66 ++++++
 rtl/atm_account_server.sv | 182 ++++++++++++++++++
 tb/tb_atm_account_server.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared op, status and FSM state constants for the ATM link
package atm_pkg;

  localparam logic [2:0] OP_AUTH     = 3'b001;
  localparam logic [2:0] OP_BALANCE  = 3'b011;
  localparam logic [2:0] OP_WITHDRAW = 3'b100;
  localparam logic [2:0] OP_DEPOSIT  = 3'b101;
  localparam logic [2:0] OP_EXIT     = 3'b110;

  localparam logic [2:0] STS_OK           = 3'd0;
  localparam logic [2:0] STS_BAD_PIN      = 3'd1;
  localparam logic [2:0] STS_NO_ACCT      = 3'd2;
  localparam logic [2:0] STS_NO_SESSION   = 3'd3;
  localparam logic [2:0] STS_INSUFFICIENT = 3'd4;
  localparam logic [2:0] STS_OVERFLOW     = 3'd5;
  localparam logic [2:0] STS_LOCKED       = 3'd6;
  localparam logic [2:0] STS_BAD_OP       = 3'd7;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

endpackage

// File: rtl/atm_account_table.sv
// rtl/atm_account_table.sv - register account table with parallel lookup and one update port
module atm_account_table #(
  parameter int NUM_ACCTS = 4,
  parameter int ACC_BASE  = 2178,
  parameter int PIN_BASE  = 4,
  parameter int INIT_BAL  = 500,
  parameter int IDX_W     = 2,
  parameter int FAIL_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       lk_acc_i,
  output logic              lk_hit_o,
  output logic [IDX_W-1:0]  lk_idx_o,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [3:0]        rd_pin_o,
  output logic [15:0]       rd_bal_o,
  output logic [FAIL_W-1:0] rd_fail_o,
  output logic              rd_lock_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [15:0]       wr_bal_i,
  input  logic [FAIL_W-1:0] wr_fail_i,
  input  logic              wr_lock_i
);

  logic [11:0]       acc_q  [NUM_ACCTS];
  logic [3:0]        pin_q  [NUM_ACCTS];
  logic [15:0]       bal_q  [NUM_ACCTS];
  logic [FAIL_W-1:0] fail_q [NUM_ACCTS];
  logic              lock_q [NUM_ACCTS];

  // Account numbers are unique, so at most one entry can match.
  always_comb begin
    lk_hit_o = 1'b0;
    lk_idx_o = '0;
    for (int k = 0; k < NUM_ACCTS; k++) begin
      if (acc_q[k] == lk_acc_i) begin
        lk_hit_o = 1'b1;
        lk_idx_o = IDX_W'(k);
      end
    end
  end

  assign rd_pin_o  = pin_q[rd_idx_i];
  assign rd_bal_o  = bal_q[rd_idx_i];
  assign rd_fail_o = fail_q[rd_idx_i];
  assign rd_lock_o = lock_q[rd_idx_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_ACCTS; k++) begin
        acc_q[k]  <= 12'(ACC_BASE + 100 * k);
        pin_q[k]  <= 4'(PIN_BASE + k);
        bal_q[k]  <= 16'(INIT_BAL);
        fail_q[k] <= '0;
        lock_q[k] <= 1'b0;
      end
    end else if (we_i) begin
      bal_q[wr_idx_i]  <= wr_bal_i;
      fail_q[wr_idx_i] <= wr_fail_i;
      lock_q[wr_idx_i] <= wr_lock_i;
    end
  end

endmodule

// File: rtl/atm_account_server.sv
// rtl/atm_account_server.sv - bank-side request/response server for the ATM front end
module atm_account_server import atm_pkg::*; #(
  parameter int NUM_ACCTS = 4,
  parameter int ACC_BASE  = 2178,
  parameter int PIN_BASE  = 4,
  parameter int INIT_BAL  = 500,
  parameter int MAX_TRIES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_acc_num,
  input  logic [3:0]  req_pin,
  input  logic [31:0] req_amount,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [2:0]  rsp_status,
  output logic [15:0] rsp_balance,
  output logic        session_active
);

  localparam int IDX_W  = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q;
  logic [11:0]       acc_q;
  logic [3:0]        pin_q;
  logic [31:0]       amt_q;
  logic              hit_q;
  logic [IDX_W-1:0]  idx_q;
  logic              sess_q, sess_d;
  logic [IDX_W-1:0]  sess_idx_q, sess_idx_d;
  logic [2:0]        status_q, status_d;
  logic [15:0]       bal_q, bal_d;

  logic              lk_hit;
  logic [IDX_W-1:0]  lk_idx, rd_idx;
  logic [3:0]        rd_pin;
  logic [15:0]       rd_bal, wr_bal;
  logic [FAIL_W-1:0] rd_fail, wr_fail, fail_inc;
  logic              rd_lock, wr_lock, tbl_we;
  logic [32:0]       sum33;

  atm_account_table #(
    .NUM_ACCTS(NUM_ACCTS), .ACC_BASE(ACC_BASE), .PIN_BASE(PIN_BASE),
    .INIT_BAL(INIT_BAL), .IDX_W(IDX_W), .FAIL_W(FAIL_W)
  ) u_table (
    .clk(clk), .rst(rst),
    .lk_acc_i(acc_q), .lk_hit_o(lk_hit), .lk_idx_o(lk_idx),
    .rd_idx_i(rd_idx), .rd_pin_o(rd_pin), .rd_bal_o(rd_bal),
    .rd_fail_o(rd_fail), .rd_lock_o(rd_lock),
    .we_i(tbl_we && (state_q == S_EXEC)), .wr_idx_i(rd_idx),
    .wr_bal_i(wr_bal), .wr_fail_i(wr_fail), .wr_lock_i(wr_lock)
  );

  assign req_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_status     = status_q;
  assign rsp_balance    = bal_q;
  assign session_active = sess_q;

  // AUTH works on the looked-up entry; every other op on the open session.
  assign rd_idx   = (op_q == OP_AUTH) ? idx_q : sess_idx_q;
  assign fail_inc = rd_fail + FAIL_W'(1);
  assign sum33    = {17'd0, rd_bal} + {1'b0, amt_q};

  always_comb begin
    status_d   = STS_OK;
    bal_d      = 16'd0;
    sess_d     = sess_q;
    sess_idx_d = sess_idx_q;
    tbl_we     = 1'b0;
    wr_bal     = rd_bal;
    wr_fail    = rd_fail;
    wr_lock    = rd_lock;
    case (op_q)
      OP_AUTH: begin
        sess_d = 1'b0;
        if (!hit_q) begin
          status_d = STS_NO_ACCT;
        end else if (rd_lock) begin
          status_d = STS_LOCKED;
        end else if (pin_q != rd_pin) begin
          status_d = STS_BAD_PIN;
          tbl_we   = 1'b1;
          wr_fail  = fail_inc;
          wr_lock  = (fail_inc >= FAIL_W'(MAX_TRIES));
        end else begin
          tbl_we     = 1'b1;
          wr_fail    = '0;
          sess_d     = 1'b1;
          sess_idx_d = idx_q;
          bal_d      = rd_bal;
        end
      end
      OP_BALANCE, OP_WITHDRAW, OP_DEPOSIT, OP_EXIT: begin
        if (!sess_q) begin
          status_d = STS_NO_SESSION;
        end else begin
          bal_d = rd_bal;
          if (op_q == OP_WITHDRAW) begin
            if (amt_q > {16'd0, rd_bal}) begin
              status_d = STS_INSUFFICIENT;
            end else begin
              tbl_we = 1'b1;
              wr_bal = rd_bal - amt_q[15:0];
              bal_d  = wr_bal;
            end
          end else if (op_q == OP_DEPOSIT) begin
            if (sum33 > 33'd65535) begin
              status_d = STS_OVERFLOW;
            end else begin
              tbl_we = 1'b1;
              wr_bal = sum33[15:0];
              bal_d  = wr_bal;
            end
          end else if (op_q == OP_EXIT) begin
            sess_d = 1'b0;
            bal_d  = 16'd0;
          end
        end
      end
      default: begin
        status_d = STS_BAD_OP;
        bal_d    = sess_q ? rd_bal : 16'd0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_EXEC;
      S_EXEC:   state_d = S_RESP;
      default:  if (rsp_ready) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      acc_q      <= '0;
      pin_q      <= '0;
      amt_q      <= '0;
      hit_q      <= 1'b0;
      idx_q      <= '0;
      sess_q     <= 1'b0;
      sess_idx_q <= '0;
      status_q   <= STS_OK;
      bal_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            acc_q <= req_acc_num;
            pin_q <= req_pin;
            amt_q <= req_amount;
          end
        end
        S_LOOKUP: begin
          hit_q <= lk_hit;
          idx_q <= lk_idx;
        end
        S_EXEC: begin
          status_q   <= status_d;
          bal_q      <= bal_d;
          sess_q     <= sess_d;
          sess_idx_q <= sess_idx_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_account_server.sv
// tb/tb_atm_account_server.sv - scoreboard bench for atm_account_server
module tb_atm_account_server;
  import atm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [11:0] req_acc_num = '0;
  logic [3:0]  req_pin = '0;
  logic [31:0] req_amount = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [2:0]  rsp_status;
  logic [15:0] rsp_balance;
  logic        session_active;

  atm_account_server dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_acc_num(req_acc_num), .req_pin(req_pin), .req_amount(req_amount),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_balance(rsp_balance), .session_active(session_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [15:0] bal;
    logic        sess;
    int          acc_edge;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  exp_t last_e;
  int   npass = 0;
  int   ntotal = 0;
  int   edge_cnt = 0;
  bit   in_rsp = 1'b0;
  bit   rnd_ready = 1'b0;
  bit   force_ready = 1'b1;

  // Reference bank state: plain balances, retry counts and lock flags per account.
  int   m_bal [4];
  int   m_fail[4];
  bit   m_lock[4];
  bit   m_sess;
  int   m_sidx;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) rsp_ready = rnd_ready ? 1'($urandom_range(0, 1)) : force_ready;

  task automatic check(input string name, input longint act, input longint exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_bal[k] = 500; m_fail[k] = 0; m_lock[k] = 1'b0;
    end
    m_sess = 1'b0; m_sidx = 0;
  endtask

  task automatic model(input logic [2:0] op, input logic [11:0] acc, input logic [3:0] pin,
                       input logic [31:0] amt, output logic [2:0] st, output logic [15:0] b);
    int k = -1;
    for (int i = 0; i < 4; i++) if (int'(acc) == 2178 + 100 * i) k = i;
    b = 16'd0;
    st = STS_OK;
    if (op == OP_AUTH) begin
      m_sess = 1'b0;
      if (k < 0) st = STS_NO_ACCT;
      else if (m_lock[k]) st = STS_LOCKED;
      else if (int'(pin) != 4 + k) begin
        st = STS_BAD_PIN;
        m_fail[k]++;
        if (m_fail[k] >= 3) m_lock[k] = 1'b1;
      end else begin
        m_fail[k] = 0; m_sess = 1'b1; m_sidx = k; b = 16'(m_bal[k]);
      end
    end else if (op == OP_BALANCE || op == OP_WITHDRAW || op == OP_DEPOSIT || op == OP_EXIT) begin
      if (!m_sess) st = STS_NO_SESSION;
      else if (op == OP_BALANCE) b = 16'(m_bal[m_sidx]);
      else if (op == OP_WITHDRAW) begin
        if (longint'(amt) > longint'(m_bal[m_sidx])) st = STS_INSUFFICIENT;
        else m_bal[m_sidx] = m_bal[m_sidx] - int'(amt);
        b = 16'(m_bal[m_sidx]);
      end else if (op == OP_DEPOSIT) begin
        if (longint'(m_bal[m_sidx]) + longint'(amt) > 65535) st = STS_OVERFLOW;
        else m_bal[m_sidx] = m_bal[m_sidx] + int'(amt);
        b = 16'(m_bal[m_sidx]);
      end else m_sess = 1'b0;
    end else begin
      st = STS_BAD_OP;
      b = m_sess ? 16'(m_bal[m_sidx]) : 16'd0;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [11:0] acc, input logic [3:0] pin,
                      input logic [31:0] amt);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin check("req_ready_timeout", 0, 1); return; end
    model(op, acc, pin, amt, e.st, e.bal);
    e.sess = m_sess;
    e.acc_edge = edge_cnt + 1;
    sbq.push_back(e);
    last_e = e;
    req_op = op; req_acc_num = acc; req_pin = pin; req_amount = amt;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(sbq.size() == 0 && req_ready) && n < 300) begin @(negedge clk); n++; end
    check("drain_timeout", (sbq.size() == 0 && req_ready) ? 1 : 0, 1);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Scoreboard monitor: the accept edge counts as the first, so rsp_valid is seen after the third.
  always @(negedge clk) begin
    if (rst) in_rsp = 1'b0;
    else if (rsp_valid && !in_rsp) begin
      in_rsp = 1'b1;
      if (sbq.size() == 0) check("unexpected_rsp", 1, 0);
      else begin
        mon_e = sbq.pop_front();
        check("rsp_status", rsp_status, mon_e.st);
        check("rsp_balance", rsp_balance, mon_e.bal);
        check("session_active", session_active, mon_e.sess);
        check("rsp_latency", edge_cnt - mon_e.acc_edge, 2);
      end
    end else if (!rsp_valid) in_rsp = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [11:0] acc;
    logic [3:0]  pin;
    logic [31:0] amt;
    int          k;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_status", rsp_status, 0);
    check("reset_rsp_balance", rsp_balance, 0);
    check("reset_session", session_active, 0);

    send(OP_AUTH, 12'd2278, 4'd4, 32'd0);
    send(OP_AUTH, 12'd2200, 4'd4, 32'd0);
    send(OP_BALANCE, 12'd0, 4'd0, 32'd0);
    send(OP_AUTH, 12'd2178, 4'd4, 32'd0);
    send(OP_BALANCE, 12'd0, 4'd0, 32'd0);
    send(OP_WITHDRAW, 12'd0, 4'd0, 32'd100);
    send(OP_DEPOSIT, 12'd0, 4'd0, 32'd2000);
    send(OP_WITHDRAW, 12'd0, 4'd0, 32'd43000);
    send(OP_WITHDRAW, 12'd0, 4'd0, 32'h0001_0000);
    send(OP_WITHDRAW, 12'd0, 4'd0, 32'd0);
    send(OP_BALANCE, 12'd0, 4'd0, 32'd0);
    send(OP_DEPOSIT, 12'd0, 4'd0, 32'd65000);
    send(OP_DEPOSIT, 12'd0, 4'd0, 32'hFFFF_FFFF);
    send(OP_DEPOSIT, 12'd0, 4'd0, 32'd63135);
    send(3'b000, 12'd0, 4'd0, 32'd0);
    wait_idle();

    pulse_rst();
    repeat (3) send(OP_AUTH, 12'd2278, 4'd4, 32'd0);
    send(OP_AUTH, 12'd2278, 4'd5, 32'd0);
    wait_idle();
    pulse_rst();
    send(OP_AUTH, 12'd2278, 4'd5, 32'd0);
    wait_idle();

    force_ready = 1'b0;
    send(OP_BALANCE, 12'd0, 4'd0, 32'd0);
    k = 0;
    while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
    req_op = OP_BALANCE; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_status", rsp_status, last_e.st);
      check("stall_rsp_balance", rsp_balance, last_e.bal);
      check("stall_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    force_ready = 1'b1;
    send(OP_EXIT, 12'd0, 4'd0, 32'd0);
    wait_idle();

    send(OP_AUTH, 12'd2178, 4'd4, 32'd0);
    send(OP_WITHDRAW, 12'd0, 4'd0, 32'd100);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    #1;
    check("midexec_rsp_valid", rsp_valid, 0);
    check("midexec_req_ready", req_ready, 1);
    check("midexec_session", session_active, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check("midexec_no_rsp", rsp_valid, 0);
    send(OP_AUTH, 12'd2178, 4'd4, 32'd0);
    wait_idle();

    rnd_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = OP_AUTH;
        3:       op = OP_BALANCE;
        4, 5:    op = OP_WITHDRAW;
        6, 7:    op = OP_DEPOSIT;
        8:       op = OP_EXIT;
        default: op = 3'($urandom_range(0, 1) ? 3'b010 : 3'b111);
      endcase
      k = $urandom_range(0, 4);
      acc = (k < 4) ? 12'(2178 + 100 * k) : 12'($urandom_range(0, 4095));
      pin = ($urandom_range(0, 3) != 0) ? 4'(4 + k) : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       amt = $urandom_range(0, 700);
        1:       amt = $urandom;
        2:       amt = $urandom_range(60000, 65535);
        default: amt = $urandom_range(0, 5000);
      endcase
      send(op, acc, pin, amt);
    end
    rnd_ready = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
